// File: rtl/i2c_config_sequencer_if.sv
// rtl/i2c_config_sequencer_if.sv - command/status bus between the sequencer and the I2C master logic
interface i2c_config_sequencer_if;
    logic [7:0] i2c_config;
    logic [6:0] i2c_dev_addr;
    logic [7:0] i2c_reg_addr;
    logic [7:0] i2c_reg_data;
    logic       i2c_busy;
    logic       i2c_nack;
    logic [7:0] i2c_read_data;

    modport master (
        output i2c_config, i2c_dev_addr, i2c_reg_addr, i2c_reg_data,
        input  i2c_busy, i2c_nack, i2c_read_data
    );

    modport slave (
        input  i2c_config, i2c_dev_addr, i2c_reg_addr, i2c_reg_data,
        output i2c_busy, i2c_nack, i2c_read_data
    );
endinterface

// File: rtl/i2c_config_sequencer.sv
// rtl/i2c_config_sequencer.sv - table-driven I2C register sequencer: one-shot init pass, then periodic polling
module i2c_config_sequencer #(
    parameter int         NUM_ENTRIES = 16,
    parameter int         INIT_COUNT  = 4,
    parameter logic [6:0] DEV_ADDR    = 7'h68,
    parameter int         POLL_DIV    = 12000,
    parameter int         RETRY_MAX   = 3,
    parameter int         TIMEOUT     = 4095,
    localparam int        AW          = $clog2(NUM_ENTRIES)
) (
    input  logic                  clk_12m,
    input  logic                  rst,
    input  logic                  tbl_we,
    input  logic [AW-1:0]         tbl_addr,
    input  logic [18:0]           tbl_wdata,
    i2c_config_sequencer_if.master bus,
    output logic [7:0]            rd_data,
    output logic [AW-1:0]         rd_index,
    output logic                  rd_valid,
    output logic                  init_done,
    output logic                  err,
    output logic [7:0]            state_debug
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int PW = $clog2(POLL_DIV);
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_CHECK     = 3'd5,
        S_POLL_WAIT = 3'd6,
        S_ERROR     = 3'd7
    } state_e;

    logic [18:0]   tbl_q [NUM_ENTRIES];
    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [18:0]   entry_q, entry_d;
    logic          fail_q, fail_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          init_done_q, init_done_d;
    logic          err_q, err_d;
    logic          busy_meta_q, busy_meta_d;
    logic          busy_sync_q, busy_sync_d;
    logic          busy_prev_q, busy_prev_d;
    logic          busy_rise, busy_fall;
    logic          active;
    logic [2:0]    mode;

    always_ff @(posedge clk_12m) begin
        if (tbl_we && (int'(tbl_addr) < NUM_ENTRIES)) begin
            tbl_q[tbl_addr] <= tbl_wdata;
        end
    end

    always_ff @(posedge clk_12m) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            poll_q      <= '0;
            entry_q     <= '0;
            fail_q      <= 1'b0;
            rdata_q     <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            busy_meta_q <= 1'b0;
            busy_sync_q <= 1'b0;
            busy_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            poll_q      <= poll_d;
            entry_q     <= entry_d;
            fail_q      <= fail_d;
            rdata_q     <= rdata_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            busy_meta_q <= busy_meta_d;
            busy_sync_q <= busy_sync_d;
            busy_prev_q <= busy_prev_d;
        end
    end

    always_comb begin
        busy_meta_d = bus.i2c_busy;
        busy_sync_d = busy_meta_q;
        busy_prev_d = busy_sync_q;
        busy_rise   = busy_sync_q & ~busy_prev_q;
        busy_fall   = ~busy_sync_q & busy_prev_q;

        state_d     = state_q;
        ptr_d       = ptr_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        poll_d      = poll_q;
        entry_d     = entry_q;
        fail_d      = fail_q;
        rdata_d     = rdata_q;
        init_done_d = init_done_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                ptr_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                entry_d = tbl_q[ptr_q];
                // Mode 0 entries bypass the bus and are counted as a successful step.
                if (tbl_q[ptr_q][18:16] == 3'd0) begin
                    fail_d  = 1'b0;
                    state_d = S_CHECK;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (busy_rise) begin
                    timer_d = '0;
                    state_d = S_WAIT_DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    fail_d  = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (busy_fall) begin
                    fail_d  = bus.i2c_nack;
                    rdata_d = bus.i2c_read_data;
                    state_d = S_CHECK;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    fail_d  = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (!fail_q) begin
                    retry_d = '0;
                    if (!init_done_q && (ptr_q == AW'(INIT_COUNT - 1))) begin
                        init_done_d = 1'b1;
                        ptr_d       = AW'(INIT_COUNT);
                        poll_d      = '0;
                        state_d     = S_POLL_WAIT;
                    end else if (ptr_q == AW'(NUM_ENTRIES - 1)) begin
                        ptr_d   = AW'(INIT_COUNT);
                        poll_d  = '0;
                        state_d = S_POLL_WAIT;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (retry_q < RW'(RETRY_MAX)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end
            end
            S_POLL_WAIT: begin
                if (poll_q == PW'(POLL_DIV - 1)) begin
                    state_d = S_FETCH;
                end else begin
                    poll_d = poll_q + 1'b1;
                end
            end
            S_ERROR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus request is presented from ISSUE through WAIT_DONE and withdrawn in CHECK.
    always_comb begin
        mode        = entry_q[18:16];
        active      = (state_q == S_ISSUE) || (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
        rd_valid    = (state_q == S_CHECK) && !fail_q && (mode >= 3'd4) && (mode <= 3'd6);
        rd_data     = rdata_q;
        rd_index    = ptr_q;
        init_done   = init_done_q;
        err         = err_q;
        state_debug = {5'b0, state_q};
    end

    assign bus.i2c_config   = active ? {5'b0, mode} : 8'h00;
    assign bus.i2c_dev_addr = active ? DEV_ADDR : 7'h00;
    assign bus.i2c_reg_addr = active ? entry_q[15:8] : 8'h00;
    assign bus.i2c_reg_data = active ? entry_q[7:0] : 8'h00;
endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb/tb_i2c_config_sequencer.sv - directed self-checking bench for i2c_config_sequencer
module tb_i2c_config_sequencer;
    localparam int NE = 8;
    localparam int IC = 2;
    localparam int PD = 20;
    localparam int RM = 3;
    localparam int TO = 30;
    localparam int AW = 3;

    localparam logic [7:0] S_IDLE = 8'd0, S_FETCH = 8'd1, S_ISSUE = 8'd2, S_WAIT_BUSY = 8'd3;
    localparam logic [7:0] S_WAIT_DONE = 8'd4, S_CHECK = 8'd5, S_POLL_WAIT = 8'd6, S_ERROR = 8'd7;

    logic          clk_12m = 1'b0;
    logic          rst = 1'b1;
    logic          tbl_we = 1'b0;
    logic [AW-1:0] tbl_addr = '0;
    logic [18:0]   tbl_wdata = '0;
    logic [7:0]    rd_data;
    logic [AW-1:0] rd_index;
    logic          rd_valid, init_done, err;
    logic [7:0]    state_debug;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int issues = 0;
    int base_issues;
    int n;
    logic [7:0]    last_data = '0;
    logic [AW-1:0] last_idx = '0;

    i2c_config_sequencer_if bus();

    i2c_config_sequencer #(
        .NUM_ENTRIES(NE), .INIT_COUNT(IC), .DEV_ADDR(7'h68),
        .POLL_DIV(PD), .RETRY_MAX(RM), .TIMEOUT(TO)
    ) dut (
        .clk_12m(clk_12m), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_wdata(tbl_wdata), .bus(bus), .rd_data(rd_data), .rd_index(rd_index),
        .rd_valid(rd_valid), .init_done(init_done), .err(err), .state_debug(state_debug)
    );

    always #5 clk_12m = ~clk_12m;

    always @(negedge clk_12m) begin
        if (rd_valid) begin
            pulses    <= pulses + 1;
            last_data <= rd_data;
            last_idx  <= rd_index;
        end
        if (state_debug == S_ISSUE) issues <= issues + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_state(input logic [7:0] s, input string tag);
        int k = 0;
        while (state_debug != s && k < 500) begin
            @(negedge clk_12m);
            k++;
        end
        check_eq(tag, state_debug, s);
    endtask

    task automatic serve(input int rise_dly, input int fall_dly, input logic nack, input logic [7:0] rdata);
        wait_state(S_ISSUE, "serve_issue");
        repeat (rise_dly) @(negedge clk_12m);
        bus.i2c_busy = 1'b1;
        repeat (fall_dly) @(negedge clk_12m);
        bus.i2c_nack      = nack;
        bus.i2c_read_data = rdata;
        bus.i2c_busy      = 1'b0;
        wait_state(S_CHECK, "serve_check");
    endtask

    task automatic measure(input logic [7:0] s, output int cnt);
        cnt = 0;
        while (state_debug == s && cnt < 200) begin
            cnt++;
            @(negedge clk_12m);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.i2c_busy = 1'b0;
        bus.i2c_nack = 1'b0;
        bus.i2c_read_data = 8'h00;
        for (int i = 0; i < NE; i++) begin
            @(negedge clk_12m);
            tbl_we   = 1'b1;
            tbl_addr = AW'(i);
            case (i)
                0:       tbl_wdata = {3'd1, 8'h6B, 8'h00};
                5:       tbl_wdata = {3'd4, 8'h3B, 8'h00};
                6:       tbl_wdata = {3'd2, 8'h10, 8'h55};
                default: tbl_wdata = 19'h0;
            endcase
        end
        @(negedge clk_12m);
        tbl_we = 1'b0;

        check_eq("rst_state", state_debug, S_IDLE);
        check_eq("rst_config", bus.i2c_config, 8'h00);
        check_eq("rst_dev_addr", bus.i2c_dev_addr, 7'h00);
        check_eq("rst_init_done", init_done, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_rd_valid", rd_valid, 1'b0);
        check_eq("rst_rd_index", rd_index, 3'd0);
        check_eq("rst_rd_data", rd_data, 8'h00);
        rst = 1'b0;

        @(negedge clk_12m);
        check_eq("first_fetch", state_debug, S_FETCH);
        check_eq("first_ptr", rd_index, 3'd0);
        @(negedge clk_12m);
        check_eq("e0_issue", state_debug, S_ISSUE);
        check_eq("e0_config", bus.i2c_config, 8'h01);
        check_eq("e0_reg_addr", bus.i2c_reg_addr, 8'h6B);
        check_eq("e0_dev_addr", bus.i2c_dev_addr, 7'h68);
        check_eq("e0_reg_data", bus.i2c_reg_data, 8'h00);
        repeat (3) @(negedge clk_12m);
        bus.i2c_busy = 1'b1;
        wait_state(S_WAIT_DONE, "e0_wait_done");
        check_eq("e0_config_hold", bus.i2c_config, 8'h01);
        check_eq("e0_reg_addr_hold", bus.i2c_reg_addr, 8'h6B);
        repeat (20) @(negedge clk_12m);
        bus.i2c_nack = 1'b0;
        bus.i2c_busy = 1'b0;
        wait_state(S_CHECK, "e0_check");
        check_eq("e0_check_config", bus.i2c_config, 8'h00);
        @(negedge clk_12m);
        check_eq("e1_fetch", state_debug, S_FETCH);
        check_eq("e1_ptr", rd_index, 3'd1);
        check_eq("e1_init_pending", init_done, 1'b0);
        @(negedge clk_12m);
        check_eq("e1_skip_check", state_debug, S_CHECK);
        @(negedge clk_12m);
        check_eq("init_poll", state_debug, S_POLL_WAIT);
        check_eq("init_done_set", init_done, 1'b1);
        check_eq("init_ptr", rd_index, 3'(IC));
        measure(S_POLL_WAIT, n);
        check_eq("init_poll_len", n, PD);
        check_eq("init_poll_fetch", state_debug, S_FETCH);

        wait_state(S_ISSUE, "e5_issue");
        check_eq("e5_ptr", rd_index, 3'd5);
        check_eq("e5_config", bus.i2c_config, 8'h04);
        check_eq("e5_reg_addr", bus.i2c_reg_addr, 8'h3B);
        serve(2, 10, 1'b0, 8'hA5);
        check_eq("e5_rd_valid", rd_valid, 1'b1);
        check_eq("e5_rd_data", rd_data, 8'hA5);
        check_eq("e5_rd_index", rd_index, 3'd5);
        base_issues = issues;

        serve(2, 10, 1'b1, 8'hA5);
        serve(2, 10, 1'b1, 8'hA5);
        serve(2, 10, 1'b0, 8'hA5);
        check_eq("e6_no_read_pulse", rd_valid, 1'b0);
        @(negedge clk_12m);
        check_eq("e6_issue_count", issues - base_issues, 3);
        check_eq("e6_err", err, 1'b0);
        check_eq("pulse_count_1", pulses, 1);
        check_eq("pulse_data_1", last_data, 8'hA5);
        check_eq("pulse_index_1", last_idx, 3'd5);

        wait_state(S_POLL_WAIT, "wrap_poll");
        check_eq("wrap_ptr", rd_index, 3'(IC));
        measure(S_POLL_WAIT, n);
        check_eq("wrap_poll_len", n, PD);
        check_eq("wrap_fetch", state_debug, S_FETCH);
        check_eq("wrap_fetch_ptr", rd_index, 3'(IC));
        check_eq("wrap_init_done", init_done, 1'b1);

        wait_state(S_ISSUE, "to_issue");
        @(negedge clk_12m);
        check_eq("to_wait_busy", state_debug, S_WAIT_BUSY);
        measure(S_WAIT_BUSY, n);
        check_eq("to_len", n, TO);
        check_eq("to_check", state_debug, S_CHECK);
        check_eq("to_config", bus.i2c_config, 8'h00);
        check_eq("to_no_pulse", rd_valid, 1'b0);
        @(negedge clk_12m);
        check_eq("to_retry_issue", state_debug, S_ISSUE);
        check_eq("to_retry_ptr", rd_index, 3'd5);
        serve(2, 10, 1'b0, 8'h5A);
        base_issues = issues;

        for (int r = 0; r <= RM; r++) serve(2, 10, 1'b1, 8'h5A);
        @(negedge clk_12m);
        check_eq("exh_state", state_debug, S_ERROR);
        check_eq("exh_err", err, 1'b1);
        check_eq("exh_config", bus.i2c_config, 8'h00);
        repeat (5) @(negedge clk_12m);
        check_eq("exh_state_hold", state_debug, S_ERROR);
        check_eq("exh_config_hold", bus.i2c_config, 8'h00);
        check_eq("exh_issue_count", issues - base_issues, RM + 1);
        check_eq("pulse_count_2", pulses, 2);
        check_eq("pulse_data_2", last_data, 8'h5A);

        rst = 1'b1;
        @(negedge clk_12m);
        check_eq("rst2_state", state_debug, S_IDLE);
        check_eq("rst2_err", err, 1'b0);
        check_eq("rst2_init_done", init_done, 1'b0);
        rst = 1'b0;
        bus.i2c_nack = 1'b0;
        @(negedge clk_12m);
        check_eq("rst2_fetch", state_debug, S_FETCH);
        check_eq("rst2_ptr", rd_index, 3'd0);
        @(negedge clk_12m);
        check_eq("rst2_issue_config", bus.i2c_config, 8'h01);
        repeat (2) @(negedge clk_12m);
        bus.i2c_busy = 1'b1;
        wait_state(S_WAIT_DONE, "mid_wait_done");
        rst = 1'b1;
        @(negedge clk_12m);
        check_eq("mid_rst_state", state_debug, S_IDLE);
        check_eq("mid_rst_config", bus.i2c_config, 8'h00);
        rst = 1'b0;
        bus.i2c_busy = 1'b0;
        @(negedge clk_12m);
        check_eq("mid_restart_fetch", state_debug, S_FETCH);
        check_eq("mid_restart_ptr", rd_index, 3'd0);
        @(negedge clk_12m);
        check_eq("mid_restart_issue", state_debug, S_ISSUE);
        repeat (6) @(negedge clk_12m);
        check_eq("mid_fall_ignored", state_debug, S_WAIT_BUSY);
        check_eq("mid_reg_addr", bus.i2c_reg_addr, 8'h6B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_config_sequencer.md
I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- NUM_ENTRIES, 16, command table depth; 2..256.
- INIT_COUNT, 4, entries 0..INIT_COUNT-1 run once after reset; 1..NUM_ENTRIES-1.
- DEV_ADDR, 7'h68, slave address driven on i2c_dev_addr.
- POLL_DIV, 12000, clk_12m cycles between poll passes; at least 2.
- RETRY_MAX, 3, re-issues allowed per entry after a NACK or timeout.
- TIMEOUT, 4095, clk_12m cycles allowed for busy to rise, or for busy to fall once high.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk_12m, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- tbl_we, in, 1, table write strobe.
- tbl_addr, in, clog2(NUM_ENTRIES), table write index.
- tbl_wdata, in, 19, table entry {mode[2:0], reg_addr[7:0], reg_data[7:0]}.
- i2c_busy, in, 1, master-logic busy level, asynchronous to clk_12m.
- i2c_nack, in, 1, master NACK flag, valid while busy is low.
- i2c_read_data, in, 8, master read byte.
- i2c_config, out, 8, mode code to master; 0 = wait.
- i2c_dev_addr, out, 7, slave address.
- i2c_reg_addr, out, 8, register address.
- i2c_reg_data, out, 8, write data.
- rd_data, out, 8, captured read byte.
- rd_index, out, clog2(NUM_ENTRIES), entry that produced rd_data.
- rd_valid, out, 1, one-cycle pulse, rd_data and rd_index valid.
- init_done, out, 1, sticky; set when the init pass completes.
- err, out, 1, sticky; set on retry exhaustion.
- state_debug, out, 8, current state code.

Function
REQ-003 Reset behaviour:
- Reset is sampled only on the rising edge of clk_12m.
- All outputs SHALL reset to 0.
- The retry counter, the poll counter and the busy synchronizer SHALL reset to 0.
- The state SHALL reset to IDLE.
- Table contents SHALL be retained through reset.

REQ-004 i2c_busy SHALL pass through a 2-flop synchronizer. Rise and fall events SHALL be edge-detected on the synchronized level.

REQ-005 Table writes:
- A table write SHALL occur on any cycle with tbl_we=1.
- A write to the entry currently latched SHALL take effect from the next fetch of that entry.

REQ-006 States and encodings: IDLE=0, FETCH=1, ISSUE=2, WAIT_BUSY=3, WAIT_DONE=4, CHECK=5, POLL_WAIT=6, ERROR=7.

REQ-007 IDLE SHALL go to FETCH one cycle after reset deasserts, with the entry pointer at 0.

REQ-008 FETCH SHALL take one cycle. It latches the entry at the pointer, then goes to ISSUE.

REQ-009 Mode code 0 in an entry:
- The entry is skipped and treated as success.
- No bus transaction is issued.

REQ-010 ISSUE and WAIT_BUSY:
- ISSUE SHALL drive i2c_config={5'b0,mode}, i2c_dev_addr=DEV_ADDR, i2c_reg_addr and i2c_reg_data from the entry.
- ISSUE SHALL then go to WAIT_BUSY.
- These outputs SHALL hold until CHECK.
- WAIT_BUSY SHALL go to WAIT_DONE on a synchronized busy rise.

REQ-011 WAIT_DONE SHALL go to CHECK on a synchronized busy fall. In the same cycle it SHALL sample i2c_nack and i2c_read_data.

REQ-012 Timeout: if WAIT_BUSY or WAIT_DONE stays TIMEOUT cycles without its edge, the block SHALL treat this as a NACK.

REQ-013 CHECK SHALL drive i2c_config=0, then take exactly one of these branches:
- On success with mode 4, 5 or 6: pulse rd_valid for one cycle, with rd_data set to the sampled byte and rd_index set to the pointer.
- On success: clear the retry count, then advance the pointer.
- On NACK or timeout with retry count < RETRY_MAX: increment the retry count and go to ISSUE.
- On NACK or timeout otherwise: go to ERROR.

REQ-014 Pointer advance:
- From INIT_COUNT-1 on the first pass: set init_done, set the pointer to INIT_COUNT, go to POLL_WAIT.
- From NUM_ENTRIES-1: wrap to INIT_COUNT and go to POLL_WAIT.
- Otherwise: increment the pointer and go to FETCH.

REQ-015 POLL_WAIT SHALL count POLL_DIV cycles, measured from POLL_WAIT entry, then go to FETCH.

REQ-016 ERROR:
- ERROR SHALL set err.
- ERROR SHALL hold i2c_config=0 and stay there until reset.

REQ-017 Field widths:
- rd_valid SHALL never assert outside CHECK.
- The counters SHALL be sized by clog2 of their parameter.
- No truncation of DEV_ADDR or of the entry fields is permitted.

Reset and Verification
REQ-018 Asserting rst in any state, including mid-transaction:
- The block SHALL return to IDLE on the next edge with i2c_config=0.
- It SHALL restart from entry 0 one cycle after deassertion.
- A busy fall arriving after reset SHALL be ignored.

REQ-019 The bench SHALL cover these directed scenarios:
- Init pass: load entry0 = {1, 8'h6B, 8'h00}; busy rises 3 cycles after ISSUE and falls 20 cycles later with nack=0 -> i2c_config=1 and i2c_reg_addr=8'h6B during the transaction; next fetch is entry1.
- Read: entry5 = {4, 8'h3B, x} returns read byte 8'hA5 -> single rd_valid pulse with rd_data=8'hA5, rd_index=5.
- NACK retry: 2 NACKs then success -> 3 issues of the same entry; err=0; retry count cleared.
- Exhaustion: RETRY_MAX+1 NACKs -> state_debug=7, err=1, i2c_config=0 held.
- Timeout: busy never rises -> timeout after TIMEOUT cycles; retry path taken.
- Poll wrap: after entry NUM_ENTRIES-1, a gap of POLL_DIV cycles, then entry INIT_COUNT re-fetched; init_done stays 1.
